// File: rtl/usb_pkt_rx.sv
`default_nettype none
// ============================================================================
//  Module   : usb_pkt_rx
//  Purpose  : UTMI receive-side packet decoder with PID, CRC5/CRC16 and length checks.
//  Revision : 1.0
// ============================================================================
module usb_pkt_rx #(
   parameter int MAX_PAYLOAD = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_active,
   input  logic        rx_error,
   output logic [3:0]  pid,
   output logic        pid_valid,
   output logic [6:0]  tok_addr,
   output logic [3:0]  tok_endp,
   output logic [10:0] frame_num,
   output logic [7:0]  data,
   output logic        data_valid,
   output logic        pkt_ok,
   output logic        pkt_err,
   output logic [2:0]  err_code
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PID   = 3'd1,
      ST_TOKEN = 3'd2,
      ST_DATA  = 3'd3,
      ST_HSK   = 3'd4,
      ST_DRAIN = 3'd5
   } state_t;

   localparam logic [4:0]  c_crc5_res  = 5'b01100;
   localparam logic [15:0] c_crc16_res = 16'h800D;
   localparam logic [10:0] c_ovf_cnt   = 11'(MAX_PAYLOAD + 2);
   localparam logic [10:0] c_cnt_max   = 11'h7FF;
   localparam logic [3:0]  c_pid_sof   = 4'b0101;
   localparam logic [2:0]  c_err_none  = 3'd0;
   localparam logic [2:0]  c_err_pid   = 3'd1;
   localparam logic [2:0]  c_err_crc   = 3'd2;
   localparam logic [2:0]  c_err_len   = 3'd3;
   localparam logic [2:0]  c_err_rx    = 3'd4;

   state_t      r_state;
   logic        r_act_d;
   logic        r_err_rx;
   logic        r_err_pid;
   logic        r_err_len;
   logic [10:0] r_cnt;
   logic [7:0]  r_buf0;
   logic [7:0]  r_buf1;
   logic [7:0]  r_tok_lo;
   logic [2:0]  r_tok_hi;
   logic [4:0]  r_crc5;
   logic [15:0] r_crc16;

   logic        w_start;
   logic        w_rxerr;
   logic        w_pid_ok;
   logic [10:0] w_cnt_inc;
   logic [4:0]  w_crc5_nx;
   logic [15:0] w_crc16_nx;
   logic        w_len_bad;
   logic        w_crc_bad;
   logic [2:0]  w_code;

   // Serial CRCs, data bits consumed LSB-first, MSB of the register is the feedback tap.
   function automatic logic [4:0] f_crc5(input logic [4:0] crc, input logic [7:0] d);
      logic [4:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (d[i] ^ c[4]) c = {c[3:0], 1'b0} ^ 5'b00101;
         else             c = {c[3:0], 1'b0};
      end
      return c;
   endfunction

   function automatic logic [15:0] f_crc16(input logic [15:0] crc, input logic [7:0] d);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (d[i] ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // A packet starts only on a fresh rx_active rise, so a packet in flight at reset release is skipped.
   assign w_start    = (r_state == ST_IDLE) && rx_active && !r_act_d;
   assign w_rxerr    = rx_active && rx_error;
   assign w_pid_ok   = (rx_data[7:4] == ~rx_data[3:0]);
   assign w_cnt_inc  = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 11'd1;
   assign w_crc5_nx  = f_crc5(r_crc5, rx_data);
   assign w_crc16_nx = f_crc16(r_crc16, rx_data);

   always_comb begin
      w_len_bad = 1'b0;
      w_crc_bad = 1'b0;
      case (r_state)
         ST_PID:   w_len_bad = 1'b1;
         ST_TOKEN: begin
            w_len_bad = (r_cnt != 11'd2);
            w_crc_bad = (r_crc5 != c_crc5_res);
         end
         ST_DATA:  begin
            w_len_bad = (r_cnt < 11'd2);
            w_crc_bad = (r_crc16 != c_crc16_res);
         end
         default:  ;
      endcase

      if (r_err_rx)                    w_code = c_err_rx;
      else if (r_err_pid)              w_code = c_err_pid;
      else if (r_err_len || w_len_bad) w_code = c_err_len;
      else if (w_crc_bad)              w_code = c_err_crc;
      else                             w_code = c_err_none;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_act_d    <= 1'b1;
         r_err_rx   <= 1'b0;
         r_err_pid  <= 1'b0;
         r_err_len  <= 1'b0;
         r_cnt      <= 11'd0;
         r_buf0     <= 8'd0;
         r_buf1     <= 8'd0;
         r_tok_lo   <= 8'd0;
         r_tok_hi   <= 3'd0;
         r_crc5     <= 5'h1F;
         r_crc16    <= 16'hFFFF;
         pid        <= 4'd0;
         pid_valid  <= 1'b0;
         tok_addr   <= 7'd0;
         tok_endp   <= 4'd0;
         frame_num  <= 11'd0;
         data       <= 8'd0;
         data_valid <= 1'b0;
         pkt_ok     <= 1'b0;
         pkt_err    <= 1'b0;
         err_code   <= 3'd0;
      end else begin
         r_act_d    <= rx_active;
         pid_valid  <= 1'b0;
         data_valid <= 1'b0;
         pkt_ok     <= 1'b0;
         pkt_err    <= 1'b0;

         if (r_state != ST_IDLE && w_rxerr) r_err_rx <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state   <= ST_PID;
                  r_err_rx  <= w_rxerr;
                  r_err_pid <= 1'b0;
                  r_err_len <= 1'b0;
                  r_cnt     <= 11'd0;
                  r_crc5    <= 5'h1F;
                  r_crc16   <= 16'hFFFF;
               end
            end

            default: begin
               if (!rx_active) begin
                  r_state  <= ST_IDLE;
                  err_code <= w_code;
                  if (w_code == c_err_none) begin
                     pkt_ok <= 1'b1;
                     if (r_state == ST_TOKEN) begin
                        if (pid == c_pid_sof) begin
                           frame_num <= {r_tok_hi, r_tok_lo};
                        end else begin
                           tok_addr <= r_tok_lo[6:0];
                           tok_endp <= {r_tok_hi, r_tok_lo[7]};
                        end
                     end
                  end else begin
                     pkt_err <= 1'b1;
                  end
               end else if (rx_error) begin
                  r_state <= ST_DRAIN;
               end else if (rx_valid) begin
                  case (r_state)
                     ST_PID: begin
                        if (w_pid_ok) begin
                           pid       <= rx_data[3:0];
                           pid_valid <= 1'b1;
                           case (rx_data[1:0])
                              2'b01:   r_state <= ST_TOKEN;
                              2'b11:   r_state <= ST_DATA;
                              default: r_state <= ST_HSK;
                           endcase
                        end else begin
                           r_err_pid <= 1'b1;
                           r_state   <= ST_DRAIN;
                        end
                     end

                     ST_TOKEN: begin
                        r_crc5 <= w_crc5_nx;
                        r_cnt  <= w_cnt_inc;
                        if (r_cnt == 11'd0) begin
                           r_tok_lo <= rx_data;
                        end else if (r_cnt == 11'd1) begin
                           r_tok_hi <= rx_data[2:0];
                        end else begin
                           r_err_len <= 1'b1;
                           r_state   <= ST_DRAIN;
                        end
                     end

                     ST_DATA: begin
                        // The two newest bytes stay buffered; they become the CRC field at end of packet.
                        if (r_cnt == c_ovf_cnt) begin
                           r_err_len <= 1'b1;
                           r_state   <= ST_DRAIN;
                        end else begin
                           r_crc16 <= w_crc16_nx;
                           r_cnt   <= w_cnt_inc;
                           r_buf0  <= r_buf1;
                           r_buf1  <= rx_data;
                           if (r_cnt >= 11'd2) begin
                              data       <= r_buf0;
                              data_valid <= 1'b1;
                           end
                        end
                     end

                     ST_HSK: begin
                        r_err_len <= 1'b1;
                        r_state   <= ST_DRAIN;
                     end

                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_usb_pkt_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_pkt_rx
//  Purpose  : Directed self-checking bench for usb_pkt_rx.
//  Revision : 1.0
// ============================================================================
module tb_usb_pkt_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_data = 8'd0;
   logic        rx_valid = 1'b0;
   logic        rx_active = 1'b0;
   logic        rx_error = 1'b0;
   logic [3:0]  pid;
   logic        pid_valid;
   logic [6:0]  tok_addr;
   logic [3:0]  tok_endp;
   logic [10:0] frame_num;
   logic [7:0]  data;
   logic        data_valid;
   logic        pkt_ok;
   logic        pkt_err;
   logic [2:0]  err_code;

   always #5 clk = ~clk;

   usb_pkt_rx #(.MAX_PAYLOAD(1023)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_active(rx_active), .rx_error(rx_error), .pid(pid), .pid_valid(pid_valid),
      .tok_addr(tok_addr), .tok_endp(tok_endp), .frame_num(frame_num), .data(data),
      .data_valid(data_valid), .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code)
   );

   int checks = 0;
   int errors = 0;
   int n_data = 0;
   int n_ok   = 0;
   int n_err  = 0;
   int n_pidv = 0;
   logic [7:0] rx_bytes [0:2047];
   logic [7:0] tx_buf [0:15];

   always @(negedge clk) begin
      if (data_valid) begin
         if (n_data < 2048) rx_bytes[n_data] = data;
         n_data++;
      end
      if (pkt_ok)    n_ok++;
      if (pkt_err)   n_err++;
      if (pid_valid) n_pidv++;
   end

   task automatic load3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2;
   endtask

   task automatic load_data(input logic [7:0] last);
      tx_buf[0] = 8'hC3; tx_buf[1] = 8'h80; tx_buf[2] = 8'h06; tx_buf[3]  = 8'h00;
      tx_buf[4] = 8'h01; tx_buf[5] = 8'h00; tx_buf[6] = 8'h00; tx_buf[7]  = 8'h40;
      tx_buf[8] = 8'h00; tx_buf[9] = 8'hDD; tx_buf[10] = last;
   endtask

   // Called just after a rising edge; tail=0 lets the next packet rise right after the verdict.
   task automatic send_pkt(input int n, input int err_at, input int tail);
      rx_active = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         rx_valid = 1'b1;
         rx_data  = tx_buf[i];
         rx_error = (i == err_at);
         @(posedge clk); #1;
      end
      rx_valid  = 1'b0;
      rx_error  = 1'b0;
      rx_active = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < tail; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({pid, pid_valid, data_valid, pkt_ok, pkt_err, err_code} !== 13'd0) begin
         errors++;
         $display("FAIL reset_ctl: got pid=%0h pv=%0b dv=%0b ok=%0b err=%0b code=%0d, expected all 0",
                  pid, pid_valid, data_valid, pkt_ok, pkt_err, err_code);
      end
      checks++;
      if ({tok_addr, tok_endp, frame_num, data} !== 30'd0) begin
         errors++;
         $display("FAIL reset_fields: got addr=%0h endp=%0h frame=%0h data=%0h, expected 0",
                  tok_addr, tok_endp, frame_num, data);
      end
   endtask

   task automatic test_token;
      int o0, e0, p0;
      o0 = n_ok; e0 = n_err; p0 = n_pidv;
      load3(8'h2D, 8'h00, 8'h10);
      send_pkt(3, -1, 3);
      checks++;
      if (n_pidv - p0 !== 1) begin errors++; $display("FAIL setup_pidv: got %0d expected 1", n_pidv - p0); end
      checks++;
      if (pid !== 4'hD) begin errors++; $display("FAIL setup_pid: got %0h expected d", pid); end
      checks++;
      if (n_ok - o0 !== 1 || n_err - e0 !== 0) begin
         errors++; $display("FAIL setup_verdict: got ok=%0d err=%0d expected ok=1 err=0", n_ok - o0, n_err - e0);
      end
      checks++;
      if (tok_addr !== 7'd0 || tok_endp !== 4'd0) begin
         errors++; $display("FAIL setup_fields: got addr=%0h endp=%0h expected 0 0", tok_addr, tok_endp);
      end
      // IN addr 1 endp 1, CRC5 field 11010 worked out by hand
      o0 = n_ok;
      load3(8'h69, 8'h81, 8'h58);
      send_pkt(3, -1, 3);
      checks++;
      if (n_ok - o0 !== 1 || tok_addr !== 7'd1 || tok_endp !== 4'd1 || pid !== 4'h9) begin
         errors++; $display("FAIL in_token: got ok=%0d addr=%0h endp=%0h pid=%0h expected 1 1 1 9",
                            n_ok - o0, tok_addr, tok_endp, pid);
      end
   endtask

   task automatic test_sof;
      int o0;
      o0 = n_ok;
      load3(8'hA5, 8'h81, 8'h58);
      send_pkt(3, -1, 3);
      checks++;
      if (n_ok - o0 !== 1 || frame_num !== 11'h081) begin
         errors++; $display("FAIL sof_frame: got ok=%0d frame=%0h expected 1 081", n_ok - o0, frame_num);
      end
      checks++;
      if (tok_addr !== 7'd1 || tok_endp !== 4'd1) begin
         errors++; $display("FAIL sof_keeps_addr: got addr=%0h endp=%0h expected 1 1", tok_addr, tok_endp);
      end
   endtask

   task automatic test_token_errors;
      int e0;
      e0 = n_err;
      load3(8'h69, 8'h81, 8'h59);
      send_pkt(3, -1, 3);
      checks++;
      if (n_err - e0 !== 1 || err_code !== 3'd2) begin
         errors++; $display("FAIL token_crc: got err=%0d code=%0d expected 1 2", n_err - e0, err_code);
      end
      checks++;
      if (tok_addr !== 7'd1) begin errors++; $display("FAIL token_crc_addr: got %0h expected 1", tok_addr); end
      e0 = n_err;
      load3(8'h69, 8'h81, 8'h00);
      send_pkt(2, -1, 3);
      checks++;
      if (n_err - e0 !== 1 || err_code !== 3'd3) begin
         errors++; $display("FAIL token_short: got err=%0d code=%0d expected 1 3", n_err - e0, err_code);
      end
   endtask

   task automatic test_data;
      int d0, o0, e0;
      logic [7:0] exp [0:7];
      exp = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
      d0 = n_data; o0 = n_ok; e0 = n_err;
      load_data(8'h94);
      send_pkt(11, -1, 3);
      checks++;
      if (n_data - d0 !== 8) begin errors++; $display("FAIL data_count: got %0d expected 8", n_data - d0); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rx_bytes[d0 + i] !== exp[i]) begin
            errors++; $display("FAIL data_byte%0d: got %0h expected %0h", i, rx_bytes[d0 + i], exp[i]);
         end
      end
      checks++;
      if (n_ok - o0 !== 1 || n_err - e0 !== 0 || pid !== 4'h3) begin
         errors++; $display("FAIL data_verdict: got ok=%0d err=%0d pid=%0h expected 1 0 3", n_ok - o0, n_err - e0, pid);
      end
   endtask

   task automatic test_data_crc_err;
      int d0, e0;
      d0 = n_data; e0 = n_err;
      load_data(8'h95);
      send_pkt(11, -1, 3);
      checks++;
      if (n_data - d0 !== 8) begin errors++; $display("FAIL crcerr_count: got %0d expected 8", n_data - d0); end
      checks++;
      if (n_err - e0 !== 1 || err_code !== 3'd2) begin
         errors++; $display("FAIL data_crc: got err=%0d code=%0d expected 1 2", n_err - e0, err_code);
      end
   endtask

   task automatic test_data_len;
      int d0, o0, e0;
      d0 = n_data; o0 = n_ok;
      load3(8'hC3, 8'h00, 8'h00);
      send_pkt(3, -1, 3);
      checks++;
      if (n_ok - o0 !== 1 || n_data - d0 !== 0 || err_code !== 3'd0) begin
         errors++; $display("FAIL zero_len: got ok=%0d data=%0d code=%0d expected 1 0 0", n_ok - o0, n_data - d0, err_code);
      end
      e0 = n_err;
      send_pkt(2, -1, 3);
      checks++;
      if (n_err - e0 !== 1 || err_code !== 3'd3) begin
         errors++; $display("FAIL data_short: got err=%0d code=%0d expected 1 3", n_err - e0, err_code);
      end
   endtask

   task automatic test_hsk;
      int o0, e0;
      o0 = n_ok;
      load3(8'hD2, 8'h00, 8'h00);
      send_pkt(1, -1, 3);
      checks++;
      if (n_ok - o0 !== 1 || pid !== 4'h2) begin
         errors++; $display("FAIL ack: got ok=%0d pid=%0h expected 1 2", n_ok - o0, pid);
      end
      e0 = n_err;
      send_pkt(2, -1, 3);
      checks++;
      if (n_err - e0 !== 1 || err_code !== 3'd3) begin
         errors++; $display("FAIL ack_extra: got err=%0d code=%0d expected 1 3", n_err - e0, err_code);
      end
   endtask

   task automatic test_bad_pid;
      int e0, p0;
      e0 = n_err; p0 = n_pidv;
      load3(8'h2E, 8'h00, 8'h10);
      send_pkt(3, -1, 3);
      checks++;
      if (n_pidv - p0 !== 0 || n_err - e0 !== 1 || err_code !== 3'd1) begin
         errors++; $display("FAIL bad_pid: got pidv=%0d err=%0d code=%0d expected 0 1 1", n_pidv - p0, n_err - e0, err_code);
      end
   endtask

   task automatic test_rx_error;
      int e0;
      e0 = n_err;
      load_data(8'h94);
      send_pkt(11, 5, 3);
      checks++;
      if (n_err - e0 !== 1 || err_code !== 3'd4) begin
         errors++; $display("FAIL rx_error: got err=%0d code=%0d expected 1 4", n_err - e0, err_code);
      end
   endtask

   task automatic test_empty;
      int e0;
      e0 = n_err;
      send_pkt(0, -1, 3);
      checks++;
      if (n_err - e0 !== 1 || err_code !== 3'd3) begin
         errors++; $display("FAIL empty: got err=%0d code=%0d expected 1 3", n_err - e0, err_code);
      end
   endtask

   task automatic test_back_to_back;
      int o0, e0, p0;
      o0 = n_ok; e0 = n_err; p0 = n_pidv;
      load3(8'hD2, 8'h00, 8'h00);
      send_pkt(1, -1, 0);
      load3(8'h2D, 8'h00, 8'h10);
      send_pkt(3, -1, 3);
      checks++;
      if (n_ok - o0 !== 2 || n_err - e0 !== 0 || n_pidv - p0 !== 2 || pid !== 4'hD) begin
         errors++; $display("FAIL back_to_back: got ok=%0d err=%0d pidv=%0d pid=%0h expected 2 0 2 d",
                            n_ok - o0, n_err - e0, n_pidv - p0, pid);
      end
   endtask

   task automatic test_overflow;
      int d0, e0;
      d0 = n_data; e0 = n_err;
      rx_active = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = 8'hC3;
      @(posedge clk); #1;
      rx_data = 8'h00;
      for (int i = 0; i < 1030; i++) begin
         @(posedge clk); #1;
      end
      rx_valid  = 1'b0;
      rx_active = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      checks++;
      if (n_data - d0 !== 1023) begin errors++; $display("FAIL ovf_count: got %0d expected 1023", n_data - d0); end
      checks++;
      if (n_err - e0 !== 1 || err_code !== 3'd3) begin
         errors++; $display("FAIL ovf_verdict: got err=%0d code=%0d expected 1 3", n_err - e0, err_code);
      end
   endtask

   task automatic test_reset_mid;
      int d0, o0, e0, p0;
      load_data(8'h94);
      rx_active = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         rx_valid = 1'b1;
         rx_data  = tx_buf[i];
         @(posedge clk); #1;
      end
      d0 = n_data; o0 = n_ok; e0 = n_err; p0 = n_pidv;
      rst = 1'b0;
      #2;
      checks++;
      if ({pid, data_valid, pkt_ok, pkt_err, err_code} !== 10'd0) begin
         errors++; $display("FAIL mid_reset_clear: got pid=%0h dv=%0b ok=%0b err=%0b code=%0d expected 0",
                            pid, data_valid, pkt_ok, pkt_err, err_code);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 5; i < 11; i++) begin
         rx_data = tx_buf[i];
         @(posedge clk); #1;
      end
      rx_valid  = 1'b0;
      rx_active = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      checks++;
      if (n_data - d0 !== 0 || n_ok - o0 !== 0 || n_err - e0 !== 0 || n_pidv - p0 !== 0) begin
         errors++; $display("FAIL mid_reset_quiet: got data=%0d ok=%0d err=%0d pidv=%0d expected 0",
                            n_data - d0, n_ok - o0, n_err - e0, n_pidv - p0);
      end
      o0 = n_ok;
      load3(8'h2D, 8'h00, 8'h10);
      send_pkt(3, -1, 3);
      checks++;
      if (n_ok - o0 !== 1 || pid !== 4'hD) begin
         errors++; $display("FAIL after_reset_setup: got ok=%0d pid=%0h expected 1 d", n_ok - o0, pid);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      rst = 1'b1;
      @(posedge clk); #1;
      test_token;
      test_sof;
      test_token_errors;
      test_data;
      test_data_crc_err;
      test_data_len;
      test_hsk;
      test_bad_pid;
      test_rx_error;
      test_empty;
      test_back_to_back;
      test_overflow;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
